// File: rtl/bus_bridge.sv
// Purpose: debug/bootstrap initiator that turns a byte command stream into
//          read/write cycles on the 65C02 system bus and returns read data or
//          status on a byte response stream.
// Latency: a bus cycle starts 1 clk after grant is seen in REQ. It lasts 1 clk
//          plus one clk per clk of i_wait. Each response byte is valid 1 clk after
//          the cycle that produced it completes.
// Backpressure: o_rx_ready is low whenever a command byte cannot be consumed.
//          i_wait stretches the bus cycle. A response is held until i_tx_ready.
//
// Ports:
//   clk, resb                 clock and asynchronous active-low reset
//   i_rx_data/_valid, o_rx_ready   command byte stream (valid/ready)
//   o_tx_data/_valid, i_tx_ready   response byte stream (valid/ready)
//   o_busreq, i_busgrant      bus ownership request / grant
//   o_addr, o_data, o_rwb, o_cycle registered bus cycle outputs
//   i_data, i_wait            read data and target stall from the system bus
module bus_bridge #(
  parameter logic [7:0] ACK_BYTE = 8'h2E,
  parameter logic [7:0] ERR_BYTE = 8'h3F
) (
  input  logic        clk,
  input  logic        resb,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busreq,
  input  logic        i_busgrant,
  output logic [15:0] o_addr,
  output logic [7:0]  o_data,
  output logic        o_rwb,
  output logic        o_cycle,
  input  logic [7:0]  i_data,
  input  logic        i_wait
);

  localparam logic [7:0] OPC_WR = 8'h57;
  localparam logic [7:0] OPC_RD = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE,   // waiting for opcode
    S_OPC,    // opcode taken, waiting for addr_hi
    S_AHI,    // addr_hi taken, waiting for addr_lo
    S_ALO,    // addr_lo taken, waiting for len
    S_LEN,    // header complete, choose write or read path
    S_WDATA,  // waiting for next write data byte
    S_REQ,    // waiting for bus grant
    S_BUS,    // bus cycle in progress
    S_RDATA,  // read byte waiting for response handshake
    S_ACK,    // write burst done, ACK byte waiting for handshake
    S_ERR     // unknown opcode, ERR byte waiting for handshake
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  rem_q, rem_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        cycle_q, cycle_d;
  logic        rwb_q, rwb_d;
  logic        busreq_q, busreq_d;
  logic [7:0]  tx_dat_q, tx_dat_d;
  logic        tx_vld_q, tx_vld_d;
  logic        rx_rdy_q, rx_rdy_d;

  logic rx_fire;
  logic tx_fire;
  logic last_beat;

  assign rx_fire   = i_rx_valid & rx_rdy_q;
  assign tx_fire   = tx_vld_q & i_tx_ready;
  // Remaining count is decremented on completion; a count of 1 here means
  // this cycle is the final one (len=0 starts at 0 and wraps through 255).
  assign last_beat = (rem_q == 8'd1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    is_wr_d  = is_wr_q;
    wdata_d  = wdata_q;
    cycle_d  = cycle_q;
    rwb_d    = rwb_q;
    busreq_d = busreq_q;
    tx_dat_d = tx_dat_q;
    tx_vld_d = tx_vld_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (i_rx_data == OPC_WR) begin
            is_wr_d = 1'b1;
            state_d = S_OPC;
          end else if (i_rx_data == OPC_RD) begin
            is_wr_d = 1'b0;
            state_d = S_OPC;
          end else begin
            // Unknown opcode: answer immediately, consume nothing more.
            tx_dat_d = ERR_BYTE;
            tx_vld_d = 1'b1;
            state_d  = S_ERR;
          end
        end
      end

      S_OPC: begin
        if (rx_fire) begin
          addr_d[15:8] = i_rx_data;
          state_d      = S_AHI;
        end
      end

      S_AHI: begin
        if (rx_fire) begin
          addr_d[7:0] = i_rx_data;
          state_d     = S_ALO;
        end
      end

      S_ALO: begin
        if (rx_fire) begin
          rem_d   = i_rx_data;
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (is_wr_q) begin
          state_d = S_WDATA;
        end else begin
          busreq_d = 1'b1;
          state_d  = S_REQ;
        end
      end

      S_WDATA: begin
        if (rx_fire) begin
          wdata_d  = i_rx_data;
          busreq_d = 1'b1;
          state_d  = S_REQ;
        end
      end

      S_REQ: begin
        // Grant is only looked at here; once in BUS the cycle runs to completion.
        if (i_busgrant) begin
          cycle_d = 1'b1;
          rwb_d   = ~is_wr_q;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        if (!i_wait) begin
          cycle_d = 1'b0;
          rwb_d   = 1'b1;
          addr_d  = addr_q + 16'd1;
          rem_d   = rem_q - 8'd1;
          if (last_beat) begin
            busreq_d = 1'b0;
          end
          if (is_wr_q) begin
            if (last_beat) begin
              tx_dat_d = ACK_BYTE;
              tx_vld_d = 1'b1;
              state_d  = S_ACK;
            end else begin
              state_d = S_WDATA;
            end
          end else begin
            tx_dat_d = i_data;
            tx_vld_d = 1'b1;
            state_d  = S_RDATA;
          end
        end
      end

      S_RDATA: begin
        if (tx_fire) begin
          tx_vld_d = 1'b0;
          state_d  = (rem_q == 8'd0) ? S_IDLE : S_REQ;
        end
      end

      S_ACK, S_ERR: begin
        if (tx_fire) begin
          tx_vld_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready is registered from the next state so it is low during reset and
    // rises on the first edge after release.
    rx_rdy_d = (state_d == S_IDLE) || (state_d == S_OPC) || (state_d == S_AHI) ||
               (state_d == S_ALO)  || (state_d == S_WDATA);
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state_q  <= S_IDLE;
      addr_q   <= 16'h0000;
      rem_q    <= 8'h00;
      is_wr_q  <= 1'b0;
      wdata_q  <= 8'h00;
      cycle_q  <= 1'b0;
      rwb_q    <= 1'b1;
      busreq_q <= 1'b0;
      tx_dat_q <= 8'h00;
      tx_vld_q <= 1'b0;
      rx_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      is_wr_q  <= is_wr_d;
      wdata_q  <= wdata_d;
      cycle_q  <= cycle_d;
      rwb_q    <= rwb_d;
      busreq_q <= busreq_d;
      tx_dat_q <= tx_dat_d;
      tx_vld_q <= tx_vld_d;
      rx_rdy_q <= rx_rdy_d;
    end
  end

  assign o_rx_ready = rx_rdy_q;
  assign o_tx_data  = tx_dat_q;
  assign o_tx_valid = tx_vld_q;
  assign o_busreq   = busreq_q;
  assign o_addr     = addr_q;
  assign o_data     = wdata_q;
  assign o_rwb      = rwb_q;
  assign o_cycle    = cycle_q;

endmodule
